jam_param: RTL and testbench

Parametrised job-assignment engine, the successor to the fixed 8×8 `JAM` block. It exhaustively enumerates all N! worker-to-job permutations and reads each cost entry from an external cost ROM over a W/J address bus. It reports the minimum total cost and the number of permutations that reach it. Unlike `JAM`, it is restartable through a START/BUSY/VALID handshake without reset, and it supports N = 2..8 workers.

---
 rtl/jam_param_if.sv | 37 +++
 rtl/jam_param.sv | 196 +++++++++++++++++++
 tb/tb_jam_param.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jam_param_if.sv
// rtl/jam_param_if.sv - START/BUSY/VALID handshake, cost ROM bus and result outputs of jam_param
// BEST_PERM is present only when JAM_BEST_PERM_EN is defined.
interface jam_param_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int SW  = 10,
  parameter int MCW = 4,
  parameter int IW  = 3
);
  logic           START;
  logic [IW-1:0]  W;
  logic [IW-1:0]  J;
  logic [CW-1:0]  Cost;
  logic           BUSY;
  logic           VALID;
  logic [SW-1:0]  MinCost;
  logic [MCW-1:0] MatchCount;
`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] BEST_PERM;
`endif

  modport master (
    input  START, Cost,
`ifdef JAM_BEST_PERM_EN
    output BEST_PERM,
`endif
    output W, J, BUSY, VALID, MinCost, MatchCount
  );

  modport slave (
    output START, Cost,
`ifdef JAM_BEST_PERM_EN
    input  BEST_PERM,
`endif
    input  W, J, BUSY, VALID, MinCost, MatchCount
  );
endinterface

// File: rtl/jam_param.sv
// rtl/jam_param.sv - exhaustive N-worker job-assignment search over an external cost ROM
// Optional JAM_BEST_PERM_EN adds the lexicographically first optimal permutation on BEST_PERM.
module jam_param #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int SW  = 10,
  parameter int MCW = 4,
  parameter int IW  = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  jam_param_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  perm_q [N];
  logic [IW-1:0]  perm_d [N];
  logic [IW-1:0]  swp    [N];
  logic [IW-1:0]  nxt_perm [N];
  logic [3:0]     k_q, k_d;
  logic [SW-1:0]  sum_q, sum_d, min_q, min_d, min_out_q, min_out_d;
  logic [MCW-1:0] cnt_q, cnt_d, cnt_out_q, cnt_out_d;
  logic [IW-1:0]  w_q, w_d, j_q, j_d;
  logic           busy_q, busy_d, valid_q, valid_d;
  logic           piv_found;
  int             piv, succ;
  logic [IW-1:0]  piv_val, succ_val;
`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0] best_q, best_d, best_out_q, best_out_d;
`endif

  // Lexicographic successor: rightmost ascent is the pivot, the suffix after it is descending.
  always_comb begin
    piv_found = 1'b0;
    piv       = 0;
    succ      = 0;
    piv_val   = '0;
    succ_val  = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        piv_found = 1'b1;
        piv       = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == piv) piv_val = perm_q[i];
    end
    for (int i = 0; i < N; i++) begin
      if (i > piv && perm_q[i] > piv_val) succ = i;
    end
    for (int i = 0; i < N; i++) begin
      if (i == succ) succ_val = perm_q[i];
    end
    for (int i = 0; i < N; i++) begin
      if (i == piv)       swp[i] = succ_val;
      else if (i == succ) swp[i] = piv_val;
      else                swp[i] = perm_q[i];
    end
    for (int i = 0; i < N; i++) begin
      nxt_perm[i] = swp[i];
      for (int s = 0; s < N; s++) begin
        if (i > piv && s == N + piv - i) nxt_perm[i] = swp[s];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    perm_d    = perm_q;
    k_d       = k_q;
    sum_d     = sum_q;
    min_d     = min_q;
    cnt_d     = cnt_q;
    min_out_d = min_out_q;
    cnt_out_d = cnt_out_q;
    w_d       = w_q;
    j_d       = j_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
`ifdef JAM_BEST_PERM_EN
    best_d     = best_q;
    best_out_d = best_out_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.START && !valid_q) begin
          for (int i = 0; i < N; i++) perm_d[i] = IW'(i);
          sum_d   = '0;
          min_d   = '1;
          cnt_d   = '0;
          k_d     = '0;
          w_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Cost arriving now belongs to the address driven in the previous step.
        if (k_q != 4'd0) sum_d = sum_q + SW'(bus.Cost);
        if (k_q == 4'(N)) begin
          state_d = S_UPDATE;
        end else begin
          k_d = k_q + 4'd1;
          if (k_q < 4'(N - 1)) begin
            w_d = IW'(k_q + 4'd1);
            for (int i = 0; i < N; i++) begin
              if (i == int'(k_q) + 1) j_d = perm_q[i];
            end
          end
        end
      end
      S_UPDATE: begin
        if (sum_q < min_q) begin
          min_d = sum_q;
          cnt_d = MCW'(1);
`ifdef JAM_BEST_PERM_EN
          for (int i = 0; i < N; i++) best_d[i*IW +: IW] = perm_q[i];
`endif
        end else if (sum_q == min_q && cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!piv_found) begin
          state_d = S_DONE;
        end else begin
          perm_d  = nxt_perm;
          sum_d   = '0;
          k_d     = '0;
          w_d     = '0;
          j_d     = nxt_perm[0];
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        min_out_d = min_q;
        cnt_out_d = cnt_q;
`ifdef JAM_BEST_PERM_EN
        best_out_d = best_q;
`endif
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < N; i++) perm_q[i] <= '0;
      k_q       <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
      min_out_q <= '0;
      cnt_out_q <= '0;
      w_q       <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef JAM_BEST_PERM_EN
      best_q     <= '0;
      best_out_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      perm_q    <= perm_d;
      k_q       <= k_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      min_out_q <= min_out_d;
      cnt_out_q <= cnt_out_d;
      w_q       <= w_d;
      j_q       <= j_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
`ifdef JAM_BEST_PERM_EN
      best_q     <= best_d;
      best_out_q <= best_out_d;
`endif
    end
  end

  assign bus.W          = w_q;
  assign bus.J          = j_q;
  assign bus.BUSY       = busy_q;
  assign bus.VALID      = valid_q;
  assign bus.MinCost    = min_out_q;
  assign bus.MatchCount = cnt_out_q;
`ifdef JAM_BEST_PERM_EN
  assign bus.BEST_PERM  = best_out_q;
`endif
endmodule

// File: tb/tb_jam_param.sv
// tb/tb_jam_param.sv - self-checking bench for jam_param (N=4 with MCW 4 and 5, N=3)
`timescale 1ns/1ps
module tb_jam_param;
  localparam int CW = 7;
  localparam int SW = 10;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start4 = 1'b0;
  logic start3 = 1'b0;
  logic [CW-1:0] c4tab [8][8];
  logic [CW-1:0] c3tab [8][8];
  logic [CW-1:0] rom4, rom4w, rom3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc4, cyc4w, cyc3;
  logic busy4_at_valid, busy3_at_valid;

  jam_param_if #(.N(4), .CW(CW), .SW(SW), .MCW(4), .IW(IW)) bus4 ();
  jam_param_if #(.N(4), .CW(CW), .SW(SW), .MCW(5), .IW(IW)) bus4w ();
  jam_param_if #(.N(3), .CW(CW), .SW(SW), .MCW(4), .IW(IW)) bus3 ();

  jam_param #(.N(4), .CW(CW), .SW(SW), .MCW(4), .IW(IW)) dut4  (.CLK(clk), .RST_N(rst_n), .bus(bus4));
  jam_param #(.N(4), .CW(CW), .SW(SW), .MCW(5), .IW(IW)) dut4w (.CLK(clk), .RST_N(rst_n), .bus(bus4w));
  jam_param #(.N(3), .CW(CW), .SW(SW), .MCW(4), .IW(IW)) dut3  (.CLK(clk), .RST_N(rst_n), .bus(bus3));

  assign bus4.START  = start4;
  assign bus4w.START = start4;
  assign bus3.START  = start3;
  assign bus4.Cost   = rom4;
  assign bus4w.Cost  = rom4w;
  assign bus3.Cost   = rom3;

  // Cost ROM: registers the address, data visible in the following cycle.
  always @(posedge clk) begin
    rom4  <= c4tab[bus4.W][bus4.J];
    rom4w <= c4tab[bus4w.W][bus4w.J];
    rom3  <= c3tab[bus3.W][bus3.J];
  end

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Walks every n-digit base-n tuple in counting order; tuples with distinct
  // digits are exactly the permutations, met in lexicographic order.
  task automatic model(input int n, input int mcw, input bit use3,
                       output int mn, output int cnt, output logic [23:0] best);
    int total;
    int d [8];
    total = 1;
    for (int i = 0; i < n; i++) total = total * n;
    mn = 1 << 30; cnt = 0; best = '0;
    for (int t = 0; t < total; t++) begin
      int x;
      int s;
      bit ok;
      bit [7:0] used;
      x = t; s = 0; ok = 1'b1; used = '0;
      for (int w = n - 1; w >= 0; w--) begin
        d[w] = x % n;
        x = x / n;
      end
      for (int w = 0; w < n; w++) begin
        if (used[d[w]]) ok = 1'b0;
        used[d[w]] = 1'b1;
      end
      if (ok) begin
        for (int w = 0; w < n; w++) s += int'(use3 ? c3tab[w][d[w]] : c4tab[w][d[w]]);
        if (s < mn) begin
          mn = s; cnt = 1;
          for (int w = 0; w < n; w++) best[w*3 +: 3] = 3'(d[w]);
        end else if (s == mn) begin
          cnt++;
        end
      end
    end
    if (cnt > (1 << mcw) - 1) cnt = (1 << mcw) - 1;
  endtask

  task automatic run(input bit do4, input bit do3, input int pulse_at);
    int cyc;
    bit got4, got4w, got3;
    cyc4 = -1; cyc4w = -1; cyc3 = -1;
    busy4_at_valid = 1'b1; busy3_at_valid = 1'b1;
    got4 = !do4; got4w = !do4; got3 = !do3;
    @(posedge clk); #1;
    start4 = do4; start3 = do3;
    @(posedge clk); #1;
    start4 = 1'b0; start3 = 1'b0;
    cyc = 0;
    n_checks++;
    if ((do4 && bus4.BUSY !== 1'b1) || (do3 && bus3.BUSY !== 1'b1)) begin
      n_fail++;
      $display("FAIL busy_rise: busy4=%b busy3=%b, required 1 for started engines", bus4.BUSY, bus3.BUSY);
    end
    while (!(got4 && got4w && got3) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start4 = (cyc == pulse_at);
      if (!got4 && bus4.VALID === 1'b1) begin got4 = 1'b1; cyc4 = cyc; busy4_at_valid = bus4.BUSY; end
      if (!got4w && bus4w.VALID === 1'b1) begin got4w = 1'b1; cyc4w = cyc; end
      if (!got3 && bus3.VALID === 1'b1) begin got3 = 1'b1; cyc3 = cyc; busy3_at_valid = bus3.BUSY; end
    end
    start4 = 1'b0;
    n_checks++;
    if (!(got4 && got4w && got3)) begin
      n_fail++;
      $display("FAIL valid_timeout: no VALID within %0d cycles", cyc);
    end
  endtask

  task automatic check4(input string tag);
    int mn, cnt, mn5, cnt5;
    logic [23:0] best, best5;
    model(4, 4, 1'b0, mn, cnt, best);
    model(4, 5, 1'b0, mn5, cnt5, best5);
    n_checks++;
    if (bus4.MinCost !== SW'(mn)) begin
      n_fail++; $display("FAIL %s_mincost4: got %0d required %0d", tag, bus4.MinCost, mn);
    end
    n_checks++;
    if (bus4.MatchCount !== 4'(cnt)) begin
      n_fail++; $display("FAIL %s_count4: got %0d required %0d", tag, bus4.MatchCount, cnt);
    end
    n_checks++;
    if (bus4w.MatchCount !== 5'(cnt5) || bus4w.MinCost !== SW'(mn5)) begin
      n_fail++; $display("FAIL %s_count4w: got %0d/%0d required %0d/%0d", tag, bus4w.MinCost, bus4w.MatchCount, mn5, cnt5);
    end
    n_checks++;
    if (cyc4 !== fact(4) * 6 + 1 || cyc4w !== fact(4) * 6 + 1) begin
      n_fail++; $display("FAIL %s_cycles4: got %0d/%0d required %0d", tag, cyc4, cyc4w, fact(4) * 6 + 1);
    end
    n_checks++;
    if (busy4_at_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_fall4: BUSY %b at VALID, required 0", tag, busy4_at_valid);
    end
`ifdef JAM_BEST_PERM_EN
    n_checks++;
    if (bus4.BEST_PERM !== best[11:0]) begin
      n_fail++; $display("FAIL %s_best4: got %h required %h", tag, bus4.BEST_PERM, best[11:0]);
    end
`endif
  endtask

  task automatic check3(input string tag);
    int mn, cnt;
    logic [23:0] best;
    model(3, 4, 1'b1, mn, cnt, best);
    n_checks++;
    if (bus3.MinCost !== SW'(mn) || bus3.MatchCount !== 4'(cnt)) begin
      n_fail++; $display("FAIL %s_result3: got %0d/%0d required %0d/%0d", tag, bus3.MinCost, bus3.MatchCount, mn, cnt);
    end
    n_checks++;
    if (cyc3 !== fact(3) * 5 + 1 || busy3_at_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_cycles3: got %0d busy %b required %0d busy 0", tag, cyc3, busy3_at_valid, fact(3) * 5 + 1);
    end
`ifdef JAM_BEST_PERM_EN
    n_checks++;
    if (bus3.BEST_PERM !== best[8:0]) begin
      n_fail++; $display("FAIL %s_best3: got %h required %h", tag, bus3.BEST_PERM, best[8:0]);
    end
`endif
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus4.W !== 3'd0 || bus4.J !== 3'd0) begin
      n_fail++; $display("FAIL reset_wj: got W=%0d J=%0d required 0/0", bus4.W, bus4.J);
    end
    n_checks++;
    if (bus4.BUSY !== 1'b0 || bus4.VALID !== 1'b0 || bus3.BUSY !== 1'b0 || bus3.VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b valid=%b required 0/0", bus4.BUSY, bus4.VALID);
    end
    n_checks++;
    if (bus4.MinCost !== '0 || bus4.MatchCount !== '0 || bus3.MinCost !== '0) begin
      n_fail++; $display("FAIL reset_results: got %0d/%0d required 0/0", bus4.MinCost, bus4.MatchCount);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus4.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_autostart: BUSY=%b required 0", bus4.BUSY);
    end
  endtask

  task automatic test_uniform();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) c4tab[w][j] = CW'(w + j);
    run(1'b1, 1'b0, 0);
    check4("uniform");
    n_checks++;
    if (bus4.MinCost !== 10'd12 || bus4.MatchCount !== 4'd15 || bus4w.MatchCount !== 5'd24) begin
      n_fail++; $display("FAIL uniform_golden: got %0d/%0d/%0d required 12/15/24", bus4.MinCost, bus4.MatchCount, bus4w.MatchCount);
    end
  endtask

  task automatic test_diag();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) c4tab[w][j] = CW'((w > j ? w - j : j - w) * 10);
    run(1'b1, 1'b0, 0);
    check4("diag");
    n_checks++;
    if (bus4.MinCost !== 10'd0 || bus4.MatchCount !== 4'd1) begin
      n_fail++; $display("FAIL diag_golden: got %0d/%0d required 0/1", bus4.MinCost, bus4.MatchCount);
    end
  endtask

  task automatic test_n3();
    int rows [9] = '{5, 1, 9, 1, 5, 9, 9, 9, 0};
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) c3tab[w][j] = CW'(rows[w*3 + j]);
    run(1'b0, 1'b1, 0);
    check3("n3");
    n_checks++;
    if (bus3.MinCost !== 10'd2 || bus3.MatchCount !== 4'd1) begin
      n_fail++; $display("FAIL n3_golden: got %0d/%0d required 2/1", bus3.MinCost, bus3.MatchCount);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int w = 0; w < 8; w++)
        for (int j = 0; j < 8; j++) begin
          c4tab[w][j] = CW'($urandom_range(0, (it == 1) ? 3 : 127));
          c3tab[w][j] = CW'($urandom_range(0, (it == 1) ? 2 : 127));
        end
      run(1'b1, 1'b1, 0);
      check4("random");
      check3("random");
    end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) c4tab[w][j] = CW'($urandom_range(0, 7));
    run(1'b1, 1'b0, 50);
    check4("start_ignored");
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus4.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL start_ignored_idle: BUSY=%b required 0", bus4.BUSY);
    end
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) c4tab[w][j] = CW'(((w + 1) % 4 == j) ? 1 : 60 + w);
    run(1'b1, 1'b0, 0);
    check4("second_run");
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) c4tab[w][j] = CW'($urandom_range(10, 127));
    run(1'b1, 1'b0, 0);
    check4("pre_reset");
    @(posedge clk); #1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus4.BUSY !== 1'b0 || bus4.VALID !== 1'b0 || bus4.W !== 3'd0 || bus4.J !== 3'd0) begin
      n_fail++; $display("FAIL midreset_flags: busy=%b valid=%b W=%0d J=%0d required all 0", bus4.BUSY, bus4.VALID, bus4.W, bus4.J);
    end
    n_checks++;
    if (bus4.MinCost !== '0 || bus4.MatchCount !== '0) begin
      n_fail++; $display("FAIL midreset_results: got %0d/%0d required 0/0", bus4.MinCost, bus4.MatchCount);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (bus4.BUSY !== 1'b0 || bus4.VALID !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: busy=%b valid=%b required 0/0", bus4.BUSY, bus4.VALID);
    end
    run(1'b1, 1'b0, 0);
    check4("post_reset");
  endtask

  initial begin
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) begin
        c4tab[w][j] = '0;
        c3tab[w][j] = '0;
      end
    test_reset();
    test_uniform();
    test_diag();
    test_n3();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
